// File: rtl/crosswalk_pkg.sv
// Shared definitions for the crosswalk controller: phase encoding, default
// phase durations and the width of the seconds-remaining timer.
package crosswalk_pkg;

    localparam int TIMER_W      = 7;
    localparam int MAX_DURATION = (1 << TIMER_W) - 1;

    localparam int DEF_GREEN_TIME   = 40;
    localparam int DEF_YELLOW_TIME  = 4;
    localparam int DEF_ALL_RED_TIME = 2;
    localparam int DEF_WALK_TIME    = 30;
    localparam int DEF_CLEAR_TIME   = 3;

    typedef enum logic [2:0] {
        ST_GREEN   = 3'd0,
        ST_YELLOW  = 3'd1,
        ST_ALL_RED = 3'd2,
        ST_WALK    = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    // Fixed phase order; CLEAR wraps back to GREEN.
    function automatic state_t next_phase(input state_t s);
        state_t n;
        case (s)
            ST_GREEN:   n = ST_YELLOW;
            ST_YELLOW:  n = ST_ALL_RED;
            ST_ALL_RED: n = ST_WALK;
            ST_WALK:    n = ST_CLEAR;
            default:    n = ST_GREEN;
        endcase
        return n;
    endfunction

    function automatic bit duration_ok(input int d);
        return (d >= 1) && (d <= MAX_DURATION);
    endfunction

endpackage

// File: rtl/crosswalk_controller_button_sync.sv
// Two-flop synchronizer plus rising-edge detector for the pedestrian button.
// The pulse is combinational off the synchronized level, one clk wide.
module button_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/crosswalk_controller.sv
// Car/pedestrian crosswalk sequencer with seconds-remaining timer.
// Define WALK_REQUEST_EN to hold GREEN until a pedestrian request is latched.
module crosswalk_controller
    import crosswalk_pkg::*;
#(
    parameter int GREEN_TIME   = DEF_GREEN_TIME,
    parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME = DEF_ALL_RED_TIME,
    parameter int WALK_TIME    = DEF_WALK_TIME,
    parameter int CLEAR_TIME   = DEF_CLEAR_TIME
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               walk_button,
    output logic [TIMER_W-1:0] master_timer,
    output logic               ped_enable,
    output logic               car_green,
    output logic               car_yellow,
    output logic               car_red,
    output logic               walk_pending
);

    if (!duration_ok(GREEN_TIME) || !duration_ok(YELLOW_TIME) ||
        !duration_ok(ALL_RED_TIME) || !duration_ok(WALK_TIME) ||
        !duration_ok(CLEAR_TIME)) begin : g_bad_duration
        $error("crosswalk_controller: every duration must be in 1..127");
    end

    localparam logic [TIMER_W-1:0] GREEN_T   = TIMER_W'(GREEN_TIME);
    localparam logic [TIMER_W-1:0] YELLOW_T  = TIMER_W'(YELLOW_TIME);
    localparam logic [TIMER_W-1:0] ALL_RED_T = TIMER_W'(ALL_RED_TIME);
    localparam logic [TIMER_W-1:0] WALK_T    = TIMER_W'(WALK_TIME);
    localparam logic [TIMER_W-1:0] CLEAR_T   = TIMER_W'(CLEAR_TIME);
    localparam logic [TIMER_W-1:0] ONE       = TIMER_W'(1);

    function automatic logic [TIMER_W-1:0] duration_of(input state_t s);
        logic [TIMER_W-1:0] d;
        case (s)
            ST_GREEN:   d = GREEN_T;
            ST_YELLOW:  d = YELLOW_T;
            ST_ALL_RED: d = ALL_RED_T;
            ST_WALK:    d = WALK_T;
            default:    d = CLEAR_T;
        endcase
        return d;
    endfunction

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               car_green_q,  car_green_d;
    logic               car_yellow_q, car_yellow_d;
    logic               car_red_q,    car_red_d;
    logic               ped_enable_q, ped_enable_d;
    logic               hold_green;

`ifdef WALK_REQUEST_EN
    logic walk_pending_q, walk_pending_d;
    logic button_rise;

    button_sync u_button_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (walk_button),
        .rise_pulse (button_rise)
    );

    assign hold_green   = (state_q == ST_GREEN) && !walk_pending_q;
    assign walk_pending = walk_pending_q;

    // Entering WALK clears the request even if a new edge arrives on that clk.
    always_comb begin
        walk_pending_d = walk_pending_q;
        if (button_rise && (state_q != ST_WALK)) begin
            walk_pending_d = 1'b1;
        end
        if ((state_d == ST_WALK) && (state_q != ST_WALK)) begin
            walk_pending_d = 1'b0;
        end
    end
`else
    logic unused_walk_button;

    assign unused_walk_button = walk_button;
    assign hold_green         = 1'b0;
    assign walk_pending       = 1'b0;
`endif

    // The last second of a phase loads the next phase's duration directly,
    // so the timer never shows 0 and there is no extra transition cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (tick) begin
            if (timer_q > ONE) begin
                timer_d = timer_q - ONE;
            end else if (!hold_green) begin
                state_d = next_phase(state_q);
                timer_d = duration_of(state_d);
            end
        end
        car_green_d  = (state_d == ST_GREEN);
        car_yellow_d = (state_d == ST_YELLOW);
        car_red_d    = (state_d == ST_ALL_RED) || (state_d == ST_WALK) ||
                       (state_d == ST_CLEAR);
        ped_enable_d = (state_d == ST_WALK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_GREEN;
            timer_q      <= GREEN_T;
            car_green_q  <= 1'b1;
            car_yellow_q <= 1'b0;
            car_red_q    <= 1'b0;
            ped_enable_q <= 1'b0;
`ifdef WALK_REQUEST_EN
            walk_pending_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            car_green_q  <= car_green_d;
            car_yellow_q <= car_yellow_d;
            car_red_q    <= car_red_d;
            ped_enable_q <= ped_enable_d;
`ifdef WALK_REQUEST_EN
            walk_pending_q <= walk_pending_d;
`endif
        end
    end

    assign master_timer = timer_q;
    assign car_green    = car_green_q;
    assign car_yellow   = car_yellow_q;
    assign car_red      = car_red_q;
    assign ped_enable   = ped_enable_q;

endmodule

// File: tb/tb_crosswalk_controller.sv
// Scoreboard bench for crosswalk_controller: stimulus queues expected lamp and
// timer snapshots, a monitor pops and compares after each tick or async sample.
module tb_crosswalk_controller;

    typedef enum int {PH_GREEN, PH_YELLOW, PH_ALL_RED, PH_WALK, PH_CLEAR} phase_t;

    typedef struct {
        string  name;
        int     timer;
        phase_t ph;
        bit     pending;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    bit   exp_pending = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       walk_button = 1'b0;
    logic       sample_now = 1'b0;
    logic [6:0] master_timer;
    logic       ped_enable, car_green, car_yellow, car_red, walk_pending;

    always #5 clk = ~clk;

    crosswalk_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .walk_button  (walk_button),
        .master_timer (master_timer),
        .ped_enable   (ped_enable),
        .car_green    (car_green),
        .car_yellow   (car_yellow),
        .car_red      (car_red),
        .walk_pending (walk_pending)
    );

    task automatic pushExp(input string name, input int timer, input phase_t ph);
        exp_t e;
        e.name    = name;
        e.timer   = timer;
        e.ph      = ph;
        e.pending = exp_pending;
        sb.push_back(e);
    endtask

    // One tick: the monitor samples #1 after the edge that consumes it.
    task automatic applyStimulus(input string name, input int timer, input phase_t ph);
        @(negedge clk);
        pushExp(name, timer, ph);
        tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Immediate sample with no clk edge involved; call shortly after a negedge.
    task automatic checkOutput(input string name, input int timer, input phase_t ph);
        pushExp(name, timer, ph);
        sample_now = 1'b1;
        #1;
        sample_now = 1'b0;
    endtask

    task automatic runDown(input string name, input phase_t ph, input int from, input int to);
        for (int t = from; t > to; t--) begin
            applyStimulus(name, t - 1, ph);
        end
    endtask

    task automatic pressButton(input int hold_clks);
        @(negedge clk);
        walk_button = 1'b1;
        repeat (hold_clks) @(posedge clk);
        @(negedge clk);
        walk_button = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        bit   g, y, r, p;
        forever begin
            @(posedge clk or posedge sample_now);
            if (sample_now || (tick && rst_n)) begin
                #1;
                checks++;
                if (sb.size() == 0) begin
                    $display("[TB] FAIL unexpected_sample: timer=%0d with no expected entry", master_timer);
                end else begin
                    e = sb.pop_front();
                    g = (e.ph == PH_GREEN);
                    y = (e.ph == PH_YELLOW);
                    r = (e.ph == PH_ALL_RED) || (e.ph == PH_WALK) || (e.ph == PH_CLEAR);
                    p = (e.ph == PH_WALK);
                    if (master_timer === 7'(e.timer) && car_green === g && car_yellow === y &&
                        car_red === r && ped_enable === p && walk_pending === e.pending) begin
                        passed++;
                    end else begin
                        $display("[TB] FAIL %s: got timer=%0d g/y/r/ped/pend=%b%b%b%b%b, expected timer=%0d g/y/r/ped/pend=%b%b%b%b%b",
                                 e.name, master_timer, car_green, car_yellow, car_red, ped_enable,
                                 walk_pending, e.timer, g, y, r, p, e.pending);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_state", 40, PH_GREEN);

        // Ticks during reset must be ignored; the first one after release counts.
        @(negedge clk);
        tick = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("tick_ignored_in_reset", 40, PH_GREEN);
        @(negedge clk);
        rst_n = 1'b1;
        pushExp("first_tick_after_reset", 39, PH_GREEN);
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;

        runDown("green_countdown", PH_GREEN, 39, 1);
`ifdef WALK_REQUEST_EN
        for (int i = 0; i < 100; i++) applyStimulus("green_hold", 1, PH_GREEN);
        @(negedge clk);
        walk_button = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("pending_after_two_clk", 1, PH_GREEN);
        @(posedge clk);
        @(negedge clk);
        #1;
        exp_pending = 1'b1;
        checkOutput("pending_after_three_clk", 1, PH_GREEN);
        walk_button = 1'b0;
`endif
        applyStimulus("green_to_yellow", 4, PH_YELLOW);
        runDown("yellow_countdown", PH_YELLOW, 4, 1);
        applyStimulus("yellow_to_all_red", 2, PH_ALL_RED);
        runDown("all_red_countdown", PH_ALL_RED, 2, 1);
        exp_pending = 1'b0;
        applyStimulus("all_red_to_walk", 30, PH_WALK);
        runDown("walk_countdown", PH_WALK, 30, 20);
        pressButton(3);
        checkOutput("walk_press_ignored", 20, PH_WALK);
        runDown("walk_countdown", PH_WALK, 20, 1);
        applyStimulus("walk_to_clear", 3, PH_CLEAR);
        pressButton(3);
`ifdef WALK_REQUEST_EN
        exp_pending = 1'b1;
`endif
        checkOutput("clear_press_latched", 3, PH_CLEAR);
        runDown("clear_countdown", PH_CLEAR, 3, 1);
        applyStimulus("clear_to_green", 40, PH_GREEN);

        runDown("green_countdown_2", PH_GREEN, 40, 1);
        applyStimulus("green_to_yellow_2", 4, PH_YELLOW);
        runDown("yellow_countdown_2", PH_YELLOW, 4, 1);
        applyStimulus("yellow_to_all_red_2", 2, PH_ALL_RED);
        runDown("all_red_countdown_2", PH_ALL_RED, 2, 1);

        // Synchronized edge detected on the same edge that enters WALK.
        @(negedge clk);
        walk_button = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_pending = 1'b0;
        pushExp("walk_entry_clear_wins", 30, PH_WALK);
        tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        walk_button = 1'b0;
        checkOutput("clear_wins_settled", 30, PH_WALK);

        runDown("walk_countdown_2", PH_WALK, 30, 17);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_mid_walk", 40, PH_GREEN);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        #20;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/crosswalk_controller.md
CROSSWALK_CONTROLLER -- requirements
Module: crosswalk_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter GREEN_TIME SHALL default to 40 and set the car-green duration in seconds.
REQ-003 Parameter YELLOW_TIME SHALL default to 4 and set the car-yellow duration in seconds.
REQ-004 Parameter ALL_RED_TIME SHALL default to 2 and set the all-red duration before walk, in seconds.
REQ-005 Parameter WALK_TIME SHALL default to 30 and set the walk duration in seconds.
REQ-006 Parameter CLEAR_TIME SHALL default to 3 and set the all-red duration after walk, in seconds.
REQ-007 Port clk SHALL be an input, 1 bit wide: the system clock.
REQ-008 Port rst_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-009 Port tick SHALL be an input, 1 bit wide: a one-clk strobe at 1 Hz.
REQ-010 Port walk_button SHALL be an input, 1 bit wide: the asynchronous pedestrian push-button, active-high.
REQ-011 Port master_timer SHALL be an output, 7 bits wide: the seconds remaining in the current phase.
REQ-012 Port ped_enable SHALL be an output, 1 bit wide: high only in WALK, and drives the pedestrian light enable.
REQ-013 Port car_green SHALL be an output, 1 bit wide: the car green lamp.
REQ-014 Port car_yellow SHALL be an output, 1 bit wide: the car yellow lamp.
REQ-015 Port car_red SHALL be an output, 1 bit wide: the car red lamp.
REQ-016 Port walk_pending SHALL be an output, 1 bit wide: a latched pedestrian request is waiting.

Function
REQ-017 The FSM SHALL have the states GREEN, YELLOW, ALL_RED, WALK and CLEAR, cycled in that order, with CLEAR returning to GREEN.
REQ-018 Exactly one of car_green, car_yellow and car_red SHALL be high, registered, and decoded from the state; car_red SHALL be high in ALL_RED, WALK and CLEAR.
REQ-019 Within a state, master_timer SHALL decrement by 1 on each clk edge where tick=1 and master_timer>1.
REQ-020 On a tick edge with master_timer==1 (except a GREEN hold), the FSM SHALL advance state and master_timer SHALL load the next state's duration on the same edge; master_timer SHALL never read 0.
REQ-021 Each state SHALL therefore last exactly its duration in ticks; there is no extra transition cycle.
REQ-022 walk_button SHALL pass through a two-flop synchronizer, and its rising edge SHALL set walk_pending one clk after the synchronized edge.
REQ-023 walk_pending SHALL clear on the edge that enters WALK; if a set and a clear coincide, the clear SHALL win.
REQ-024 Rising edges seen while in WALK SHALL be ignored.
REQ-025 Rising edges seen in CLEAR, GREEN, YELLOW or ALL_RED SHALL latch, and held or repeated presses SHALL not re-trigger.
REQ-026 tick SHALL be ignored while rst_n=0; a tick on the first edge after reset release SHALL be honoured.
REQ-027 Every duration parameter SHALL be in the range 1..127, and elaboration SHALL fail outside that range.

Reset
REQ-028 While rst_n=0, the outputs SHALL be: state GREEN, master_timer=GREEN_TIME, car_green=1, car_yellow=0, car_red=0, ped_enable=0, walk_pending=0, and synchronizer flops=0.
REQ-029 Reset asserted mid-WALK SHALL drop ped_enable and restore GREEN immediately, without waiting for clk.

Configuration
REQ-030 Macro WALK_REQUEST_EN SHALL select request-driven operation.
REQ-031 When WALK_REQUEST_EN is defined, GREEN SHALL hold at master_timer==1 until walk_pending=1, then advance to YELLOW on the next tick.
REQ-032 When WALK_REQUEST_EN is not defined, the FSM SHALL cycle unconditionally, the synchronizer SHALL be removed, walk_pending SHALL be tied to 0, and walk_button SHALL be unused.

Structure
REQ-033 A shared package SHALL hold the state encoding (3-bit enum), the default duration constants, and the 7-bit timer width constant.
REQ-034 Synchronization and edge detection SHALL live in sub-module button_sync, with ports clk, rst_n, async_in and rise_pulse.
REQ-035 The FSM, timer and lamp decode SHALL stay in crosswalk_controller.

Verification
REQ-036 Release reset and send 40 ticks with WALK_REQUEST_EN undefined -> master_timer runs 40..1, and on tick 40 the state is YELLOW with master_timer=4 and car_yellow=1.
REQ-037 With the default build, run one full cycle -> ped_enable=1 for exactly 30 ticks, master_timer=30..1 during WALK, and GREEN is re-entered with master_timer=40.
REQ-038 With WALK_REQUEST_EN defined and no press -> GREEN holds at master_timer=1 for 100 ticks; pulse walk_button -> walk_pending=1 three clk later, and the next tick enters YELLOW.
REQ-039 Press during WALK -> walk_pending stays 0; press during CLEAR -> walk_pending=1 and clears when the next WALK is entered.
REQ-040 Synchronized edge lands on the WALK-entry edge -> walk_pending=0 afterward (clear wins).
REQ-041 Assert rst_n=0 mid-WALK at master_timer=17, between clk edges -> ped_enable=0, car_green=1 and master_timer=40 with no clk edge.
